// File: rtl/alu_ctrl_decode_if.sv
// ALU control types and the issue-side / datapath-side handshake bundle of the decoder.
package p_alu;
    typedef enum logic [3:0] {
        ADD = 4'd0, AND = 4'd1, XOR = 4'd2, SHL = 4'd3, SHR = 4'd4,
        ASL = 4'd5, ASR = 4'd6, ROL = 4'd7, ROR = 4'd8, INVALID = 4'hF
    } e_core;

    typedef enum logic [1:0] {ID = 2'd0, NEG = 2'd1, NOT = 2'd2, ZERO = 2'd3} e_operand;

    typedef struct packed {
        logic       en;
        logic [3:0] amt;
    } s_shift;

    typedef struct packed {
        e_core    op;
        e_operand a_op;
        e_operand b_op;
        e_operand out_op;
        s_shift   pre_shift;
    } s_control;
endpackage

interface alu_ctrl_if #(parameter int unsigned CNT_W = 8);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr;
    logic                out_valid;
    logic                out_ready;
    p_alu::s_control     ctrl;
    logic                illegal;
    logic [CNT_W-1:0]    illegal_cnt;

    modport master (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, ctrl, illegal, illegal_cnt
    );
    modport slave (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, ctrl, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Decodes ALU instruction words into s_control words behind a 2-entry output buffer,
// flagging illegal opcodes and counting them with saturation.
module alu_ctrl_decode #(
    parameter int unsigned CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_ctrl_if.master bus
);
    import p_alu::*;

    localparam int unsigned SH_W    = $bits(s_shift);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} e_state;

    e_state            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    s_control          head_ctrl_q;
    logic              head_ill_q;
    s_control          tail_ctrl_q;
    logic              tail_ill_q;
    logic [CNT_W-1:0]  cnt_q;

    s_control          dec_ctrl;
    logic              dec_ill;
    logic              push;
    logic              pop;
    logic              unused_instr;

    assign unused_instr = ^bus.instr[31:4+SH_W];

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // Opcode table; shift-class and illegal ops carry no pre-shift.
    always_comb begin
        dec_ctrl.op        = ADD;
        dec_ctrl.a_op      = ID;
        dec_ctrl.b_op      = ID;
        dec_ctrl.out_op    = ID;
        dec_ctrl.pre_shift = s_shift'(bus.instr[4 +: SH_W]);
        dec_ill            = 1'b0;
        case (bus.instr[3:0])
            4'd1:  dec_ctrl.b_op = NEG;
            4'd2:  dec_ctrl.op = AND;
            4'd3:  begin
                dec_ctrl.op     = AND;
                dec_ctrl.a_op   = NOT;
                dec_ctrl.b_op   = NOT;
                dec_ctrl.out_op = NOT;
            end
            4'd4:  dec_ctrl.op = XOR;
            4'd5:  begin
                dec_ctrl.op     = XOR;
                dec_ctrl.out_op = NOT;
            end
            4'd6:  begin dec_ctrl.op = SHL; dec_ctrl.pre_shift = '0; end
            4'd7:  begin dec_ctrl.op = SHR; dec_ctrl.pre_shift = '0; end
            4'd8:  begin dec_ctrl.op = ASL; dec_ctrl.pre_shift = '0; end
            4'd9:  begin dec_ctrl.op = ASR; dec_ctrl.pre_shift = '0; end
            4'd10: begin dec_ctrl.op = ROL; dec_ctrl.pre_shift = '0; end
            4'd11: begin dec_ctrl.op = ROR; dec_ctrl.pre_shift = '0; end
            4'd12: dec_ctrl.b_op = ZERO;
            4'd13: begin dec_ctrl.a_op = NEG; dec_ctrl.b_op = ZERO; end
            4'd14: begin dec_ctrl.a_op = NOT; dec_ctrl.b_op = ZERO; end
            4'd15: begin
                dec_ctrl.op        = INVALID;
                dec_ctrl.pre_shift = '0;
                dec_ill            = 1'b1;
            end
            default: ;
        endcase
    end

    // Buffer FSM; head registers drive ctrl/illegal directly and hold when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_ctrl_q <= '0;
            head_ill_q  <= 1'b0;
            tail_ctrl_q <= '0;
            tail_ill_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (push && dec_ill && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (bus.flush) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: if (push) begin
                        head_ctrl_q <= dec_ctrl;
                        head_ill_q  <= dec_ill;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                    ONE: if (push && pop) begin
                        head_ctrl_q <= dec_ctrl;
                        head_ill_q  <= dec_ill;
                    end else if (push) begin
                        tail_ctrl_q <= dec_ctrl;
                        tail_ill_q  <= dec_ill;
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                    FULL: if (pop) begin
                        head_ctrl_q <= tail_ctrl_q;
                        head_ill_q  <= tail_ill_q;
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                    default: begin
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.ctrl        = head_ctrl_q;
    assign bus.illegal     = head_ill_q;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed and random stimulus with a queue scoreboard for alu_ctrl_decode (CNT_W=2).
module tb_alu_ctrl_decode;
    import p_alu::*;

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        s_control c;
        logic     ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_ctrl_if #(.CNT_W(CNT_W)) bus ();
    alu_ctrl_decode #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t             sb[$];
    exp_t             head_m;
    logic [CNT_W-1:0] cnt_m;

    function automatic exp_t mk(e_core c, e_operand a, e_operand b, e_operand o,
                                s_shift sh, logic ill);
        exp_t e;
        e.c.op        = c;
        e.c.a_op      = a;
        e.c.b_op      = b;
        e.c.out_op    = o;
        e.c.pre_shift = sh;
        e.ill         = ill;
        return e;
    endfunction

    function automatic exp_t expect_of(logic [31:0] ins);
        s_shift sh;
        sh = s_shift'(ins[8:4]);
        case (ins[3:0])
            4'd0:  return mk(ADD, ID, ID, ID, sh, 1'b0);
            4'd1:  return mk(ADD, ID, NEG, ID, sh, 1'b0);
            4'd2:  return mk(AND, ID, ID, ID, sh, 1'b0);
            4'd3:  return mk(AND, NOT, NOT, NOT, sh, 1'b0);
            4'd4:  return mk(XOR, ID, ID, ID, sh, 1'b0);
            4'd5:  return mk(XOR, ID, ID, NOT, sh, 1'b0);
            4'd6:  return mk(SHL, ID, ID, ID, '0, 1'b0);
            4'd7:  return mk(SHR, ID, ID, ID, '0, 1'b0);
            4'd8:  return mk(ASL, ID, ID, ID, '0, 1'b0);
            4'd9:  return mk(ASR, ID, ID, ID, '0, 1'b0);
            4'd10: return mk(ROL, ID, ID, ID, '0, 1'b0);
            4'd11: return mk(ROR, ID, ID, ID, '0, 1'b0);
            4'd12: return mk(ADD, ID, ZERO, ID, sh, 1'b0);
            4'd13: return mk(ADD, NEG, ZERO, ID, sh, 1'b0);
            4'd14: return mk(ADD, NOT, ZERO, ID, sh, 1'b0);
            default: return mk(INVALID, ID, ID, ID, '0, 1'b1);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, drive one cycle of inputs, advance the model.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic fl);
        bit push;
        bit pop;
        exp_t e;
        @(negedge clk);
        chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
        chk("ctrl", 64'(bus.ctrl), 64'(head_m.c));
        chk("illegal", 64'(bus.illegal), 64'(head_m.ill));
        chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(cnt_m));
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        e    = expect_of(ins);
        push = iv && (sb.size() < 2);
        pop  = ordy && (sb.size() > 0);
        if (pop) void'(sb.pop_front());
        if (push && !fl) sb.push_back(e);
        if (fl) sb.delete();
        if (push && e.ill && (cnt_m != '1)) cnt_m = cnt_m + CNT_W'(1);
        if (sb.size() > 0) head_m = sb[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.instr     = '0;
        sb.delete();
        head_m = '0;
        cnt_m  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.instr     = '0;
        head_m = '0;
        cnt_m  = '0;
        do_reset();
        cycle(0, 32'h0, 0, 0);

        // SUB with 1-cycle latency
        cycle(1, 32'h0000_0001, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // backpressure: ADD, XOR fill, OR refused while full
        cycle(1, 32'h0000_01A0, 0, 0);
        cycle(1, 32'h0000_0054, 0, 0);
        cycle(1, 32'h0000_0003, 0, 0);
        cycle(0, 32'h0, 0, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // simultaneous push/pop in ONE with a pre-shifted MOV then SHL
        cycle(1, 32'h0000_01FC, 0, 0);
        cycle(1, 32'h0000_01F6, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // illegal opcode five times, counter saturates at 3
        for (int i = 0; i < 5; i++) cycle(1, 32'hFFFF_FFFF, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // flush while FULL with in_valid high (no transfer), then flush in ONE
        do_reset();
        cycle(1, 32'h0000_0002, 0, 0);
        cycle(1, 32'h0000_0005, 0, 0);
        cycle(1, 32'h0000_000F, 0, 1);
        cycle(0, 32'h0, 0, 0);
        cycle(1, 32'h0000_000D, 0, 0);
        cycle(1, 32'h0000_000F, 1, 1);
        cycle(0, 32'h0, 1, 0);

        // reset mid-stream drops entries in flight
        cycle(1, 32'h0000_000E, 0, 0);
        cycle(1, 32'h0000_000F, 0, 0);
        do_reset();
        cycle(0, 32'h0, 1, 0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
